// File: rtl/cpu16_pkg.sv
// Shared types and default widths for the CPU16 memory subsystem.
// Holds the arbiter state encoding used by mem_arbiter.
package cpu16_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the CPU port (0) and the I/O/DMA port (1).
// Tie policy set by MEM_ARBITER_ROUND_ROBIN_EN (defined: alternate, undefined: port 0).
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic winner
);

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
  logic unused_owner;
  assign unused_owner = owner;
`endif

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      winner = ~owner;
`else
      winner = 1'b0;
`endif
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// Optional round-robin tie-break via MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter
  import cpu16_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              busy_q, busy_d;
  logic              winner;
  logic              resp_read;

  mem_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .owner  (owner_q),
    .winner (winner)
  );

  // RESP arbitrates exactly like IDLE so a held request is served back-to-back.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (req0 || req1) begin
          state_d     = GRANT;
          owner_d     = winner;
          we_d        = winner ? we1 : we0;
          ram_addr_d  = winner ? addr1 : addr0;
          ram_wdata_d = winner ? wdata1 : wdata0;
          ram_we_d    = winner ? we1 : we0;
          gnt0_d      = ~winner;
          gnt1_d      = winner;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        state_d   = RESP;
        rvalid0_d = ~owner_q;
        rvalid1_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // ram_q only becomes valid during RESP, so read data is steered straight through.
  assign resp_read = (state_q == RESP) && !we_q;
  assign rdata0    = (resp_read && !owner_q) ? ram_q : '0;
  assign rdata1    = (resp_read && owner_q) ? ram_q : '0;

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, shadow-memory reference model
// and a scoreboard monitor. Tie expectations follow MEM_ARBITER_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] rdata0, rdata1, ram_wdata, ram_q;
  logic [AW-1:0] ram_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clock = ~clock;

  // Single-port synchronous RAM with a preload path used only while in reset.
  logic [DW-1:0] mem [256];
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [DW-1:0] preload_data = '0;

  always @(posedge clock) begin
    if (preload_en) mem[preload_addr] <= preload_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  typedef struct { logic port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } gnt_exp_t;
  typedef struct { logic port; logic [DW-1:0] data; } rsp_exp_t;

  gnt_exp_t      gnt_q[$];
  rsp_exp_t      rsp_q[$];
  logic [DW-1:0] shadow [256];
  logic          model_owner;
  int            checks = 0;
  int            failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic model_tie();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return !model_owner;
`else
    return 1'b0;
`endif
  endfunction

  // Accesses complete in grant order; shadow memory updates in that same order.
  task automatic push_access(input logic port, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    gnt_exp_t g;
    rsp_exp_t r;
    g.port = port; g.we = we; g.addr = a; g.wdata = d;
    r.port = port;
    if (we) begin
      shadow[a] = d;
      r.data = '0;
    end else begin
      r.data = shadow[a];
    end
    gnt_q.push_back(g);
    rsp_q.push_back(r);
    model_owner = port;
  endtask

  gnt_exp_t mon_g;
  rsp_exp_t mon_r;

  always @(negedge clock) begin
    if (!reset) begin
      check_output("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      check_output("rvalid_exclusive", {31'd0, rvalid0 & rvalid1}, 32'd0);
      check_output("ram_we_outside_grant", {31'd0, ram_we & ~(gnt0 | gnt1)}, 32'd0);
      if (!rvalid0) check_output("rdata0_idle_zero", {16'd0, rdata0}, 32'd0);
      if (!rvalid1) check_output("rdata1_idle_zero", {16'd0, rdata1}, 32'd0);
      if (gnt0 || gnt1) begin
        if (gnt_q.size() == 0) begin
          check_output("unexpected_gnt", 32'd1, 32'd0);
        end else begin
          mon_g = gnt_q.pop_front();
          check_output("gnt_port", {31'd0, gnt1}, {31'd0, mon_g.port});
          check_output("ram_we_on_gnt", {31'd0, ram_we}, {31'd0, mon_g.we});
          check_output("ram_addr_on_gnt", {24'd0, ram_addr}, {24'd0, mon_g.addr});
          if (mon_g.we) check_output("ram_wdata_on_gnt", {16'd0, ram_wdata}, {16'd0, mon_g.wdata});
        end
      end
      if (rvalid0 || rvalid1) begin
        if (rsp_q.size() == 0) begin
          check_output("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          mon_r = rsp_q.pop_front();
          check_output("rvalid_port", {31'd0, rvalid1}, {31'd0, mon_r.port});
          check_output("rdata", {16'd0, (rvalid1 ? rdata1 : rdata0)}, {16'd0, mon_r.data});
        end
      end
    end
  end

  // Drives one or two simultaneous requests and follows the requester handshake.
  task automatic apply_stimulus(input logic use0, input logic use1,
                                input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic win;
    bit   done;
    done = 0;
    req0 = use0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = use1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (use0 && use1) begin
      win = model_tie();
      if (win) begin
        push_access(1'b1, w1, a1, d1);
        push_access(1'b0, w0, a0, d0);
      end else begin
        push_access(1'b0, w0, a0, d0);
        push_access(1'b1, w1, a1, d1);
      end
    end else if (use0) begin
      push_access(1'b0, w0, a0, d0);
    end else if (use1) begin
      push_access(1'b1, w1, a1, d1);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req0 && gnt0) req0 = 1'b0;
      if (req1 && gnt1) req1 = 1'b0;
      if (!req0 && !req1) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      check_output("handshake_timeout", 32'd1, 32'd0);
      req0 = 1'b0;
      req1 = 1'b0;
    end
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]    exp_tie [4];
    logic [1:0]    got_tie [4];
    int            n_gnt, n_rv;
    int            rv_cyc [3];
    bit            in_window;
    logic [DW-1:0] d;

    // Preload RAM and shadow while the DUT is held in reset.
    for (int i = 0; i < 256; i++) begin
      d = DW'($urandom);
      if (i == 5) d = 16'h1234;
      if (i == 8'h20) d = 16'h1357;
      shadow[i] = d;
      @(negedge clock);
      preload_en = 1'b1; preload_addr = AW'(i); preload_data = d;
    end
    @(negedge clock);
    preload_en = 1'b0;

    check_output("reset_gnt0", {31'd0, gnt0}, 32'd0);
    check_output("reset_gnt1", {31'd0, gnt1}, 32'd0);
    check_output("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
    check_output("reset_rvalid1", {31'd0, rvalid1}, 32'd0);
    check_output("reset_rdata0", {16'd0, rdata0}, 32'd0);
    check_output("reset_rdata1", {16'd0, rdata1}, 32'd0);
    check_output("reset_ram_addr", {24'd0, ram_addr}, 32'd0);
    check_output("reset_ram_we", {31'd0, ram_we}, 32'd0);
    check_output("reset_ram_wdata", {16'd0, ram_wdata}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);

    reset = 1'b0;
    model_owner = 1'b1;
    @(negedge clock);

    // Both ports held for four accesses; first tie after reset belongs to port 0.
    for (int k = 0; k < 4; k++) begin
      exp_tie[k] = {1'b0, model_tie()};
      push_access(exp_tie[k][0], 1'b0, (exp_tie[k][0] ? 8'h31 : 8'h30), '0);
      got_tie[k] = 2'd3;
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
    n_gnt = 0;
    for (int i = 0; i < 40 && n_gnt < 4; i++) begin
      @(negedge clock);
      if (gnt0 || gnt1) begin
        got_tie[n_gnt] = {1'b0, gnt1};
        n_gnt++;
        if (n_gnt == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    check_output("tie_grant0", {30'd0, got_tie[0]}, 32'd0);
    check_output("tie_grant1", {30'd0, got_tie[1]}, 32'd1);
    check_output("tie_grant2", {30'd0, got_tie[2]}, 32'd0);
    check_output("tie_grant3", {30'd0, got_tie[3]}, 32'd1);
`else
    check_output("tie_grant0", {30'd0, got_tie[0]}, 32'd0);
    check_output("tie_grant1", {30'd0, got_tie[1]}, 32'd0);
    check_output("tie_grant2", {30'd0, got_tie[2]}, 32'd0);
    check_output("tie_grant3", {30'd0, got_tie[3]}, 32'd0);
`endif
    @(negedge clock);

    // Read latency from IDLE: gnt one cycle after sampling, rvalid two.
    push_access(1'b0, 1'b0, 8'h05, '0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    @(negedge clock);
    check_output("lat_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge clock);
    check_output("lat_rvalid0", {31'd0, rvalid0}, 32'd1);
    check_output("lat_rdata0", {16'd0, rdata0}, 32'h1234);
    @(negedge clock);

    // Port 1 write then read-back from port 0.
    apply_stimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 8'h10, 16'hBEEF);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, '0, 1'b0, '0, '0);
    check_output("beef_in_ram", {16'd0, mem[8'h10]}, 32'hBEEF);

    // Reset during the GRANT cycle of a write must leave RAM untouched.
    @(negedge clock);
    begin
      gnt_exp_t g;
      g.port = 1'b0; g.we = 1'b1; g.addr = 8'h20; g.wdata = 16'hAAAA;
      gnt_q.push_back(g);
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'hAAAA;
    @(negedge clock);
    check_output("abort_in_grant", {31'd0, gnt0}, 32'd1);
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0;
    gnt_q.delete();
    rsp_q.delete();
    #1;
    check_output("abort_ram_we_low", {31'd0, ram_we}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_owner = 1'b1;
    repeat (4) @(negedge clock);
    check_output("abort_mem_unchanged", {16'd0, mem[8'h20]}, 32'h1357);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h20, '0, 1'b0, '0, '0);

    // Three back-to-back reads on port 0.
    for (int k = 0; k < 3; k++) push_access(1'b0, 1'b0, AW'(8'h40 + k), '0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
    n_gnt = 0; n_rv = 0; in_window = 0;
    for (int i = 0; i < 30 && n_rv < 3; i++) begin
      @(negedge clock);
      if (gnt0) begin
        in_window = 1;
        n_gnt++;
        if (n_gnt == 3) req0 = 1'b0;
        else addr0 = AW'(8'h40 + n_gnt);
      end
      if (in_window) check_output("b2b_busy", {31'd0, busy}, 32'd1);
      if (rvalid0) begin
        rv_cyc[n_rv] = i;
        n_rv++;
      end
    end
    req0 = 1'b0;
    check_output("b2b_rvalid_count", 32'(n_rv), 32'd3);
    if (n_rv == 3) begin
      check_output("b2b_spacing_a", 32'(rv_cyc[1] - rv_cyc[0]), 32'd2);
      check_output("b2b_spacing_b", 32'(rv_cyc[2] - rv_cyc[1]), 32'd2);
    end
    @(negedge clock);

    // Randomized single and contending accesses against the shadow model.
    for (int t = 0; t < 60; t++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      apply_stimulus(mode != 1, mode != 0,
                     1'($urandom), AW'($urandom), DW'($urandom),
                     1'($urandom), AW'($urandom), DW'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    check_output("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
    check_output("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
